// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - state encoding and shared constants for the 2:1 round-robin arbiter
package mux_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_GRANT0 = 2'd1;
    localparam state_t ST_GRANT1 = 2'd2;

    localparam int STAT_W = 16;

    function automatic state_t grant_state(input logic n);
        return n ? ST_GRANT1 : ST_GRANT0;
    endfunction

endpackage

// File: rtl/mux_sel_2to1.sv
// rtl/mux_sel_2to1.sv - 2:1 valid/data steering, forced to zero while no grant is held
module mux_sel_2to1 #(
    parameter int WIDTH = 8
) (
    input  logic             sel_i,
    input  logic             busy_i,
    input  logic             valid0_i,
    input  logic [WIDTH-1:0] data0_i,
    input  logic             valid1_i,
    input  logic [WIDTH-1:0] data1_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        valid_o = 1'b0;
        data_o  = '0;
        if (busy_i) begin
            valid_o = sel_i ? valid1_i : valid0_i;
            data_o  = sel_i ? data1_i  : data0_i;
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter sharing one 2:1 datapath with a per-grant hold limit
// Optional per-requester beat counters are built when MUX_ARB_STATS_EN is defined.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] gnt_cnt0,
    output logic [STAT_W-1:0] gnt_cnt1
`endif
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [HW-1:0]   hold_q, hold_d;

    logic gnt_n;
    logic own_valid;
    logic oth_valid;
    logic beat;

    assign gnt_n     = (state_q == ST_GRANT1);
    assign own_valid = gnt_n ? req1_valid : req0_valid;
    assign oth_valid = gnt_n ? req0_valid : req1_valid;
    assign beat      = busy && own_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            hold_q       <= hold_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        hold_d       = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (req0_valid && req1_valid) begin
                    state_d = grant_state(!last_grant_q);
                end else if (req0_valid) begin
                    state_d = ST_GRANT0;
                end else if (req1_valid) begin
                    state_d = ST_GRANT1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                // An owner dropping valid hands over immediately; the hold limit only bites on a beat.
                if (!own_valid) begin
                    state_d      = oth_valid ? grant_state(!gnt_n) : ST_IDLE;
                    last_grant_d = gnt_n;
                    hold_d       = '0;
                end else if (beat && (hold_q == HOLD_MAX) && oth_valid) begin
                    state_d      = grant_state(!gnt_n);
                    last_grant_d = gnt_n;
                    hold_d       = '0;
                end else if (beat && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_comb begin
        busy       = (state_q != ST_IDLE);
        sel        = gnt_n;
        req0_ready = (state_q == ST_GRANT0) && out_ready;
        req1_ready = (state_q == ST_GRANT1) && out_ready;
    end

    mux_sel_2to1 #(
        .WIDTH(WIDTH)
    ) u_sel (
        .sel_i    (sel),
        .busy_i   (busy),
        .valid0_i (req0_valid),
        .data0_i  (req0_data),
        .valid1_i (req1_valid),
        .data1_i  (req1_data),
        .valid_o  (out_valid),
        .data_o   (out_data)
    );

`ifdef MUX_ARB_STATS_EN
    logic [STAT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (req0_ready && req0_valid && (cnt0_q != '1)) cnt0_q <= cnt0_q + 1'b1;
            if (req1_ready && req1_valid && (cnt1_q != '1)) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed and randomized self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             v0, v1, out_ready;
    logic [WIDTH-1:0] d0, d1;
    logic             req0_ready, req1_ready, out_valid, sel, busy;
    logic [WIDTH-1:0] out_data;
`ifdef MUX_ARB_STATS_EN
    logic [15:0]      gnt_cnt0, gnt_cnt1;
`endif

    int total = 0;
    int bad   = 0;

    // Reference: current owner (-1 = nobody), unsaturated run length of the current grant, last owner.
    int m_owner;
    int m_run;
    int m_last;
    int beats[$];

    mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (v0),
        .req0_data  (d0),
        .req0_ready (req0_ready),
        .req1_valid (v1),
        .req1_data  (d1),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .sel        (sel),
        .busy       (busy)
`ifdef MUX_ARB_STATS_EN
        ,
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
`endif
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_run   = 0;
        m_last  = 1;
    endtask

    task automatic model_edge();
        logic own, oth;
        if (m_owner < 0) begin
            if (v0 && v1)  m_owner = 1 - m_last;
            else if (v0)   m_owner = 0;
            else if (v1)   m_owner = 1;
        end else begin
            own = (m_owner == 0) ? v0 : v1;
            oth = (m_owner == 0) ? v1 : v0;
            if (!own) begin
                m_last  = m_owner;
                m_run   = 0;
                m_owner = oth ? 1 - m_owner : -1;
            end else if (out_ready) begin
                m_run++;
                if (m_run >= MAX_HOLD && oth) begin
                    m_last  = m_owner;
                    m_owner = 1 - m_owner;
                    m_run   = 0;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic             e_valid;
        logic [WIDTH-1:0] e_data;
        e_valid = 1'b0;
        e_data  = '0;
        if (m_owner == 0) begin e_valid = v0; e_data = d0; end
        if (m_owner == 1) begin e_valid = v1; e_data = d1; end
        check({tag, ".out_valid"},  out_valid,  e_valid);
        check({tag, ".out_data"},   out_data,   e_data);
        check({tag, ".req0_ready"}, req0_ready, (m_owner == 0) && out_ready);
        check({tag, ".req1_ready"}, req1_ready, (m_owner == 1) && out_ready);
        check({tag, ".sel"},        sel,        m_owner == 1);
        check({tag, ".busy"},       busy,       m_owner >= 0);
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic cycle(input string tag);
        #1;
        check_outputs(tag);
        if (out_valid && out_ready) beats.push_back(int'(sel));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_seq(input string tag, input int pat[$]);
        check({tag, ".count"}, beats.size(), pat.size());
        for (int i = 0; i < pat.size(); i++)
            check($sformatf("%s.beat%0d", tag, i), (i < beats.size()) ? beats[i] : 32'hFFFF, pat[i]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"},  out_valid,  1'b0);
        check({tag, ".out_data"},   out_data,   8'h00);
        check({tag, ".req0_ready"}, req0_ready, 1'b0);
        check({tag, ".req1_ready"}, req1_ready, 1'b0);
        check({tag, ".sel"},        sel,        1'b0);
        check({tag, ".busy"},       busy,       1'b0);
    endtask

    initial begin
        int pat[$];
        logic acc0, acc1;

        // 1: reset with random inputs, no clock edge yet
        rst_n     = 1'b0;
        v0        = 1'($urandom);
        v1        = 1'($urandom);
        d0        = 8'($urandom);
        d1        = 8'($urandom);
        out_ready = 1'($urandom);
        model_reset();
        #1;
        check_all_zero("t1_reset");
        @(negedge clk);
        rst_n = 1'b1;
        v0 = 1'b0; v1 = 1'b0; out_ready = 1'b1;
        repeat (3) cycle("t1_idle");
        #1 check("t1.busy", busy, 1'b0);

        // 2: single requester 0
        v0 = 1'b1; d0 = 8'hA5;
        cycle("t2_arb");
        #1;
        check("t2.sel", sel, 1'b0);
        check("t2.out_valid", out_valid, 1'b1);
        check("t2.out_data", out_data, 8'hA5);
        check("t2.req0_ready", req0_ready, 1'b1);
        check("t2.req1_ready", req1_ready, 1'b0);
        cycle("t2_beat");
        v0 = 1'b0;
        cycle("t2_drop");

        // 3: both valid continuously -> 4/4/4 alternation starting at requester 0
        do_reset();
        v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22; out_ready = 1'b1;
        beats.delete();
        repeat (13) cycle("t3");
        pat = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        check_seq("t3", pat);

        // 4: backpressure during GRANT1
        d1 = 8'h3C; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t4.req1_ready", req1_ready, 1'b0);
            check("t4.out_data", out_data, 8'h3C);
            check("t4.sel", sel, 1'b1);
            cycle("t4_stall");
        end
        out_ready = 1'b1;
        beats.delete();
        repeat (5) cycle("t4_resume");
        pat = '{1, 1, 1, 1, 0};
        check_seq("t4", pat);

        // 5: requester 0 drops after 2 beats -> bubble then full run for requester 1
        do_reset();
        v0 = 1'b1; v1 = 1'b0; d0 = 8'h5A; d1 = 8'h6B;
        repeat (3) cycle("t5_run0");
        v0 = 1'b0; v1 = 1'b1;
        #1 check("t5.bubble_valid", out_valid, 1'b0);
        cycle("t5_bubble");
        v0 = 1'b1;
        beats.delete();
        repeat (6) cycle("t5_run1");
        pat = '{1, 1, 1, 1, 0, 0};
        check_seq("t5", pat);

        // 6: async reset in the middle of GRANT1
        do_reset();
        v0 = 1'b0; v1 = 1'b1;
        repeat (2) cycle("t6_pre");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("t6_reset");
        @(negedge clk);
        rst_n = 1'b1;
        v0 = 1'b1; v1 = 1'b1;
        cycle("t6_arb");
        #1;
        check("t6.sel", sel, 1'b0);
        check("t6.busy", busy, 1'b1);

        // Random traffic with valid/data held until accepted, plus occasional valid drops
        do_reset();
        for (int n = 0; n < 400; n++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            acc0 = (m_owner == 0) && v0 && out_ready;
            acc1 = (m_owner == 1) && v1 && out_ready;
            cycle("rnd");
            if (!v0 || acc0 || $urandom_range(0, 19) == 0) begin
                v0 = 1'($urandom);
                d0 = 8'($urandom);
            end
            if (!v1 || acc1 || $urandom_range(0, 19) == 0) begin
                v1 = 1'($urandom);
                d1 = 8'($urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
